// File: rtl/izhikevich_pkg.sv
`default_nettype none
// ============================================================================
// Module   : izhikevich_pkg
// Purpose  : Shared widths, Q8 model constants and FSM state encoding for the
//            Izhikevich neuron core and its dv datapath.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package izhikevich_pkg;

  // Default datapath width and fractional bits.
  localparam int c_n = 18;
  localparam int c_q = 8;

  // Model parameters, Q8 encoded.
  localparam int c_a_q8   = 5;       // 0.02
  localparam int c_b_q8   = 51;      // 0.2
  localparam int c_c_q8   = -16640;  // -65
  localparam int c_d_q8   = 2048;    // 8
  localparam int c_vth_q8 = 7680;    // 30

  // Coefficients of the membrane equation, Q8 encoded.
  localparam int c_k004_q8 = 10;     // 0.04
  localparam int c_k5_q8   = 1280;   // 5
  localparam int c_k140_q8 = 35840;  // 140

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DV   = 3'd1,
    S_DW   = 3'd2,
    S_UPD  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_dv.sv
`default_nettype none
// ============================================================================
// Module   : calc_dv
// Purpose  : Combinational membrane increment
//            dv = (0.04*v*v + 5*v + 140 - w + cur) * step, fixed point.
// Ports    : v, w    - current membrane / recovery state
//            cur     - input current
//            step    - integration timestep
//            dv      - membrane increment
// Revision : 1.0 - initial release
// ============================================================================
module calc_dv
  import izhikevich_pkg::*;
#(
  parameter int N = c_n,
  parameter int Q = c_q
) (
  input  logic signed [N-1:0] v,
  input  logic signed [N-1:0] w,
  input  logic signed [N-1:0] cur,
  input  logic signed [N-1:0] step,
  output logic signed [N-1:0] dv
);

  localparam logic signed [N-1:0] c_k004 = N'(c_k004_q8);
  localparam logic signed [N-1:0] c_k5   = N'(c_k5_q8);
  localparam logic signed [N-1:0] c_k140 = N'(c_k140_q8);
  localparam logic signed [N+2:0] c_max  = (N+3)'((2**(N-1)) - 1);
  localparam logic signed [N+2:0] c_min  = -(N+3)'(2**(N-1));

  // Full 2N-bit product, arithmetic shift by Q, keep the low N bits.
  function automatic logic signed [N-1:0] fx_mul(input logic signed [N-1:0] a,
                                                 input logic signed [N-1:0] b);
    logic signed [2*N-1:0] p;
    p = (2*N)'(a) * (2*N)'(b);
    return N'(p >>> Q);
  endfunction

  logic signed [N-1:0] w_v04;
  logic signed [N-1:0] w_t1;
  logic signed [N-1:0] w_t2;
  logic signed [N+2:0] w_sum;
  logic signed [N-1:0] w_sat;

  assign w_v04 = fx_mul(c_k004, v);
  assign w_t1  = fx_mul(w_v04, v);
  assign w_t2  = fx_mul(c_k5, v);

  // Five-term sum carried with three guard bits so a large positive
  // membrane cannot wrap the bracket negative before the step multiply.
  assign w_sum = (N+3)'(w_t1) + (N+3)'(w_t2) + (N+3)'(c_k140)
               - (N+3)'(w) + (N+3)'(cur);

  always_comb begin
    w_sat = N'(w_sum);
    if (w_sum > c_max) begin
      w_sat = N'(c_max);
    end else if (w_sum < c_min) begin
      w_sat = N'(c_min);
    end
  end

  assign dv = fx_mul(w_sat, step);

endmodule
`default_nettype wire

// File: rtl/izhikevich_neuron_core.sv
`default_nettype none
// ============================================================================
// Module   : izhikevich_neuron_core
// Purpose  : Single Izhikevich neuron, one Euler integration step per start.
//            Sequence IDLE -> DV -> DW -> UPD -> CHK -> IDLE.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            start           - request one step (accepted in IDLE only)
//            load            - preload v/w from v_load/w_load (IDLE only)
//            v_load, w_load  - preload values
//            i_in, step      - input current and timestep, latched on start
//            v_out, w_out    - registered membrane / recovery state
//            busy            - step in progress
//            done            - one-cycle pulse at step completion
//            spike           - one-cycle pulse with done on threshold crossing
// Revision : 1.0 - initial release
// ============================================================================
module izhikevich_neuron_core
  import izhikevich_pkg::*;
#(
  parameter int N    = c_n,
  parameter int Q    = c_q,
  parameter int A    = c_a_q8,
  parameter int B    = c_b_q8,
  parameter int C    = c_c_q8,
  parameter int D    = c_d_q8,
  parameter int V_TH = c_vth_q8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                load,
  input  logic signed [N-1:0] v_load,
  input  logic signed [N-1:0] w_load,
  input  logic signed [N-1:0] i_in,
  input  logic signed [N-1:0] step,
  output logic signed [N-1:0] v_out,
  output logic signed [N-1:0] w_out,
  output logic                busy,
  output logic                done,
  output logic                spike
);

  localparam logic signed [N-1:0]   c_a   = N'(A);
  localparam logic signed [N-1:0]   c_b   = N'(B);
  localparam logic signed [N-1:0]   c_c   = N'(C);
  localparam logic signed [N-1:0]   c_d   = N'(D);
  localparam logic signed [N-1:0]   c_vth = N'(V_TH);
  // Recovery reset value is B*C, formed the same way as the datapath multiply.
  localparam logic signed [2*N-1:0] c_bc    = (2*N)'(c_b) * (2*N)'(c_c);
  localparam logic signed [N-1:0]   c_w_rst = N'(c_bc >>> Q);

  function automatic logic signed [N-1:0] fx_mul(input logic signed [N-1:0] a,
                                                 input logic signed [N-1:0] b);
    logic signed [2*N-1:0] p;
    p = (2*N)'(a) * (2*N)'(b);
    return N'(p >>> Q);
  endfunction

  // Two's complement add clamped to the N-bit range.
  function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = (N+1)'(a) + (N+1)'(b);
    if (s[N] != s[N-1]) begin
      return s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
    return s[N-1:0];
  endfunction

  state_t              r_state;
  logic signed [N-1:0] r_v;
  logic signed [N-1:0] r_w;
  logic signed [N-1:0] r_dv;
  logic signed [N-1:0] r_dw;
  logic signed [N-1:0] r_cur;
  logic signed [N-1:0] r_step;
  logic                r_done;
  logic                r_spike;

  logic signed [N-1:0] w_dv;
  logic signed [N-1:0] w_bv;
  logic signed [N-1:0] w_bvw;
  logic signed [N-1:0] w_dwa;
  logic signed [N-1:0] w_dw;

  calc_dv #(
    .N (N),
    .Q (Q)
  ) u_calc_dv (
    .v    (r_v),
    .w    (r_w),
    .cur  (r_cur),
    .step (r_step),
    .dv   (w_dv)
  );

  // Recovery increment, each product truncated where it is formed.
  assign w_bv  = fx_mul(c_b, r_v);
  assign w_bvw = w_bv - r_w;
  assign w_dwa = fx_mul(w_bvw, c_a);
  assign w_dw  = fx_mul(w_dwa, r_step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_v     <= c_c;
      r_w     <= c_w_rst;
      r_dv    <= '0;
      r_dw    <= '0;
      r_cur   <= '0;
      r_step  <= '0;
      r_done  <= 1'b0;
      r_spike <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_spike <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Load wins over start when both arrive together.
          if (load) begin
            r_v <= v_load;
            r_w <= w_load;
          end else if (start) begin
            r_cur   <= i_in;
            r_step  <= step;
            r_state <= S_DV;
          end
        end
        S_DV: begin
          r_dv    <= w_dv;
          r_state <= S_DW;
        end
        S_DW: begin
          r_dw    <= w_dw;
          r_state <= S_UPD;
        end
        S_UPD: begin
          r_v     <= sat_add(r_v, r_dv);
          r_w     <= sat_add(r_w, r_dw);
          r_state <= S_CHK;
        end
        S_CHK: begin
          if (r_v >= c_vth) begin
            r_v     <= c_c;
            r_w     <= sat_add(r_w, c_d);
            r_spike <= 1'b1;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign v_out = r_v;
  assign w_out = r_w;
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign spike = r_spike;

endmodule
`default_nettype wire

// File: tb/tb_izhikevich_neuron_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_izhikevich_neuron_core
// Purpose  : Scoreboard bench for izhikevich_neuron_core. Stimulus pushes the
//            expected result and completion cycle of each step; a monitor
//            pops and compares whenever done is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_izhikevich_neuron_core;

  localparam int N = 18;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                load;
  logic signed [N-1:0] v_load;
  logic signed [N-1:0] w_load;
  logic signed [N-1:0] i_in;
  logic signed [N-1:0] step;
  logic signed [N-1:0] v_out;
  logic signed [N-1:0] w_out;
  logic                busy;
  logic                done;
  logic                spike;

  typedef struct {
    int    v;
    int    w;
    bit    sp;
    int    cyc;
    string name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  izhikevich_neuron_core dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .load   (load),
    .v_load (v_load),
    .w_load (w_load),
    .i_in   (i_in),
    .step   (step),
    .v_out  (v_out),
    .w_out  (w_out),
    .busy   (busy),
    .done   (done),
    .spike  (spike)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (done) begin
      done_cnt = done_cnt + 1;
      if (q.size() == 0) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = q.pop_front();
        check({e.name, "_cycle"}, cyc, e.cyc);
        check({e.name, "_v"}, int'(v_out), e.v);
        check({e.name, "_w"}, int'(w_out), e.w);
        check({e.name, "_spike"}, int'(spike), int'(e.sp));
        check({e.name, "_busy"}, int'(busy), 0);
      end
    end else if (spike) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL spike_without_done: spike=1 at cycle %0d, required 0", cyc);
    end
  end

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while (q.size() != 0 && k < bound) begin
      @(negedge clk);
      k = k + 1;
    end
    if (q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // Preload, issue one step, then scramble i_in/step while it is in flight.
  task automatic run_step(input string name, input int vl, input int wl,
                          input int ic, input int st,
                          input int ev, input int ew, input bit esp);
    @(negedge clk);
    load   = 1'b1;
    v_load = vl[N-1:0];
    w_load = wl[N-1:0];
    @(negedge clk);
    load  = 1'b0;
    start = 1'b1;
    i_in  = ic[N-1:0];
    step  = st[N-1:0];
    q.push_back('{v: ev, w: ew, sp: esp, cyc: cyc + 5'd4 + 1, name: name});
    @(negedge clk);
    start = 1'b0;
    i_in  = ~i_in;
    step  = ~step;
    wait_drain(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a;
    int dc;
    rst    = 1'b1;
    start  = 1'b0;
    load   = 1'b0;
    v_load = '0;
    w_load = '0;
    i_in   = '0;
    step   = '0;
    repeat (2) @(negedge clk);
    check("rst_v", int'(v_out), -16640);
    check("rst_w", int'(w_out), -3315);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_spike", int'(spike), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_v", int'(v_out), -16640);

    run_step("load_spike", 8960,   0,      0,      0,   -16640, 2048,   1'b1);
    run_step("neg_dv",     0,      256,    -35840, 256, -256,   251,    1'b0);
    run_step("rest_140",   0,      0,      0,      256, -16640, 2048,   1'b1);
    run_step("sat_v",      131000, 0,      35840,  256, -16640, 2557,   1'b1);
    run_step("vth_equal",  7680,   0,      0,      0,   -16640, 2048,   1'b1);
    run_step("vth_below",  7679,   0,      0,      0,   7679,   0,      1'b0);
    run_step("sat_w",      8960,   131000, 0,      0,   -16640, 131071, 1'b1);

    // Load and start together: load applied, start dropped.
    @(negedge clk);
    load   = 1'b1;
    start  = 1'b1;
    v_load = 18'sd5000;
    w_load = 18'sd77;
    i_in   = '0;
    step   = 18'sd256;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("ldst_v", int'(v_out), 5000);
    check("ldst_w", int'(w_out), 77);
    check("ldst_busy", int'(busy), 0);

    // Start held high: three back-to-back steps, load pulsed mid-step ignored.
    @(negedge clk);
    load   = 1'b1;
    v_load = 18'sd8960;
    w_load = '0;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b1;
    i_in  = '0;
    step  = '0;
    a     = cyc + 1;
    q.push_back('{v: -16640, w: 2048, sp: 1'b1, cyc: a + 4,  name: "b2b_1"});
    q.push_back('{v: -16640, w: 2048, sp: 1'b0, cyc: a + 9,  name: "b2b_2"});
    q.push_back('{v: -16640, w: 2048, sp: 1'b0, cyc: a + 14, name: "b2b_3"});
    repeat (7) @(negedge clk);
    load   = 1'b1;
    v_load = 18'sd8960;
    w_load = 18'sd500;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_drain(30);

    // Reset asserted while the step is in DW.
    @(negedge clk);
    load   = 1'b1;
    v_load = '0;
    w_load = '0;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b1;
    step  = 18'sd256;
    i_in  = '0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    dc  = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_v", int'(v_out), -16640);
    check("abort_w", int'(w_out), -3315);
    check("abort_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt, dc);

    run_step("after_abort", 0, 256, -35840, 256, -256, 251, 1'b0);

    wait_drain(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/izhikevich_neuron_core.md
IZHIKEVICH_NEURON_CORE -- requirements
Module: izhikevich_neuron_core

Interface
REQ-001 SHALL have parameter N, default 18: datapath width, signed two's complement.
REQ-002 SHALL have parameter Q, default 8: fractional bits.
REQ-003 SHALL have parameters A=5 (0.02), B=51 (0.2), C=-16640 (-65), D=2048 (8), V_TH=7680 (30), all Q8 encoded.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request one integration step.
REQ-007 SHALL have port load, input, 1: overwrite state with v_load/w_load.
REQ-008 SHALL have ports v_load and w_load, input, N: state preload values.
REQ-009 SHALL have port i_in, input, N: input current, sampled on start acceptance.
REQ-010 SHALL have port step, input, N: timestep, sampled on start acceptance.
REQ-011 SHALL have ports v_out and w_out, output, N: registered membrane and recovery state.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at step completion.
REQ-014 SHALL have port spike, output, 1: one-cycle pulse, coincident with done, when threshold is crossed.

Function
REQ-015 SHALL implement FSM IDLE -> DV -> DW -> UPD -> CHK -> IDLE, advancing one state per clock once start is accepted.
REQ-016 SHALL accept start only in IDLE; start while busy is ignored, not queued.
REQ-017 SHALL apply load only in IDLE, at the next edge; load while busy is ignored; load and start together in IDLE: load applied, start dropped.
REQ-018 SHALL register i_in and step when start is accepted; later changes do not affect the step in flight.
REQ-019 DV SHALL register dv = (0.04*v*v + 5*v + 140 - w + i)*step, where 0.04 = 10 in Q8.
REQ-020 DW SHALL register dw = ((B*v) - w)*A, then *step, with each product truncated at that point.
REQ-021 UPD SHALL set v <= v+dv and w <= w+dw.
REQ-022 CHK SHALL, if v >= V_TH (signed), set v <= C, w <= w+D, and spike <= 1; done <= 1 in all cases.
REQ-023 Multiplies SHALL form the full 2N-bit signed product and take bits [N+Q-1:Q] (arithmetic floor).
REQ-024 The UPD and CHK additions SHALL saturate to [-2^(N-1), 2^(N-1)-1] rather than wrap.
REQ-025 Latency: start accepted at edge k; done/spike high for exactly the cycle following edge k+4; v_out/w_out final at that same edge.
REQ-026 busy SHALL be low in the done cycle; a start in the done cycle is accepted (back-to-back steps, 5-cycle period).

Reset
REQ-027 rst SHALL force, asynchronously: state IDLE, v_out=C (-16640), w_out=-3315 (B*C), busy=0, done=0, spike=0, dv/dw registers 0.
REQ-028 rst mid-step SHALL abort the step; no done or spike pulse is produced for the aborted step.

Structure
REQ-029 Shared package izhikevich_pkg SHALL hold N, Q, the default A/B/C/D/V_TH constants, the 0.04/5/140 Q8 constants, and the FSM state enum.
REQ-030 The dv expression SHALL reuse the existing calc_dv module as the single sub-module; the dw path, saturation and FSM are local.

Verification
REQ-031 Reset: assert rst mid-DW -> immediately v_out=-16640, w_out=-3315, busy=0; no done pulse afterwards.
REQ-032 load v=8960 (35), w=0; start with step=0, i=0 -> done and spike 4 cycles after start; v_out=-16640, w_out=2048.
REQ-033 load v=0, w=256; start with step=256, i=-35840 -> dv=-256, dw=-5; v_out=-256, w_out=251; spike=0.
REQ-034 load v=0, w=0; start with step=256, i=0 -> v=140 >= 30 -> spike=1, v_out=-16640, w_out=2048.
REQ-035 start held high continuously -> done every 5 cycles; start and load pulsed while busy -> no effect on that step or its result.
REQ-036 load v=131000, w=0, step=256, i=35840 -> v_out=-16640 with spike=1 (sum saturated, not wrapped negative).
